glb_token_dispatcher: RTL and testbench

//  Parametrised multi-channel GLB-to-PE token streamer; successor to the fixed

---
 rtl/glb_token_dispatcher.sv | 189 ++++++++++++++++++
 tb/tb_glb_token_dispatcher.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_token_dispatcher.sv
// Multi-channel GLB-to-PE token streamer: round-robin reads into per-channel
// token FIFOs, with psum write-back taking priority on the shared GLB port.
module glb_token_dispatcher #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 3,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         PASS_START,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_base,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  ch_len,
  input  logic [ADDR_WIDTH-1:0]        psum_base,
  input  logic [LEN_WIDTH-1:0]         psum_len,
  output logic                         glb_read_ready,
  output logic [ADDR_WIDTH-1:0]        glb_read_addr,
  input  logic                         glb_read_valid,
  input  logic [DATA_WIDTH-1:0]        glb_read_data,
  output logic                         glb_write_ready,
  output logic                         WEB,
  output logic [ADDR_WIDTH-1:0]        glb_write_addr,
  output logic [DATA_WIDTH-1:0]        glb_write_data,
  output logic [NUM_CH*DATA_WIDTH-1:0] tok_data,
  output logic [NUM_CH-1:0]            tok_valid,
  input  logic [NUM_CH-1:0]            tok_ready,
  input  logic [DATA_WIDTH-1:0]        pe_psum_data,
  input  logic                         pe_psum_valid,
  output logic                         pe_psum_ready,
  output logic                         busy,
  output logic                         pass_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0] base_r [NUM_CH];
  logic [LEN_WIDTH-1:0]  len_r  [NUM_CH];
  logic [LEN_WIDTH-1:0]  issued [NUM_CH];
  logic [ADDR_WIDTH-1:0] psum_base_r;
  logic [LEN_WIDTH-1:0]  psum_len_r;
  logic [LEN_WIDTH-1:0]  psum_cnt;
  logic [CW-1:0]         rr_ptr;
  logic [CW-1:0]         rd_ch;
  logic [CW-1:0]         grant;
  logic                  rd_pend;

  logic [DATA_WIDTH-1:0] mem  [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0]         wptr [NUM_CH];
  logic [PW-1:0]         rptr [NUM_CH];
  logic [OW-1:0]         occ  [NUM_CH];

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic              rd_fail;
  logic              rd_push;
  logic              found;
  logic              read_req;
  logic              write_fire;
  logic              all_issued;
  logic              fifos_empty;
  logic              inflight;
  int unsigned       idx;

  always_comb begin
    rd_fail       = rd_pend && !glb_read_valid;
    rd_push       = rd_pend && glb_read_valid;
    pe_psum_ready = (state == RUN || state == DRAIN) && (psum_cnt < psum_len_r);
    write_fire    = pe_psum_ready && pe_psum_valid;
    all_issued    = 1'b1;
    fifos_empty   = 1'b1;
    elig          = '0;
    push          = '0;
    pop           = '0;
    tok_valid     = '0;
    tok_data      = '0;
    inflight      = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      inflight     = rd_pend && (rd_ch == CW'(c));
      // A channel whose read just failed sits out one cycle so the retry
      // re-reads the rolled-back address rather than skipping past it.
      elig[c]      = (state == RUN) && (issued[c] < len_r[c]) &&
                     ((occ[c] + OW'(inflight)) < OW'(FIFO_DEPTH)) &&
                     !(rd_fail && rd_ch == CW'(c));
      push[c]      = rd_push && (rd_ch == CW'(c));
      tok_valid[c] = (occ[c] != '0);
      pop[c]       = tok_valid[c] && tok_ready[c];
      if (tok_valid[c]) tok_data[c*DATA_WIDTH +: DATA_WIDTH] = mem[c][rptr[c]];
      if (issued[c] != len_r[c]) all_issued = 1'b0;
      if (occ[c] != '0) fifos_empty = 1'b0;
    end

    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && elig[CW'(idx)]) begin
        found = 1'b1;
        grant = CW'(idx);
      end
    end
    read_req = found && !write_fire;

    glb_read_ready  = read_req;
    glb_read_addr   = read_req ? base_r[grant] + ADDR_WIDTH'(issued[grant]) : '0;
    glb_write_ready = write_fire;
    WEB             = !write_fire;
    glb_write_addr  = write_fire ? psum_base_r + ADDR_WIDTH'(psum_cnt) : '0;
    glb_write_data  = write_fire ? pe_psum_data : '0;
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++)
      if (push[c]) mem[c][wptr[c]] <= glb_read_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      pass_done   <= 1'b0;
      psum_base_r <= '0;
      psum_len_r  <= '0;
      psum_cnt    <= '0;
      rr_ptr      <= '0;
      rd_ch       <= '0;
      rd_pend     <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        base_r[c] <= '0;
        len_r[c]  <= '0;
        issued[c] <= '0;
        wptr[c]   <= '0;
        rptr[c]   <= '0;
        occ[c]    <= '0;
      end
    end else begin
      pass_done <= 1'b0;
      rd_pend   <= read_req;
      if (read_req) begin
        rd_ch  <= grant;
        rr_ptr <= (int'(grant) == NUM_CH - 1) ? '0 : grant + CW'(1);
      end
      if (write_fire) psum_cnt <= psum_cnt + LEN_WIDTH'(1);

      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (read_req && grant == CW'(c)) issued[c] <= issued[c] + LEN_WIDTH'(1);
        else if (rd_fail && rd_ch == CW'(c)) issued[c] <= issued[c] - LEN_WIDTH'(1);
        if (push[c]) wptr[c] <= wptr[c] + PW'(1);
        if (pop[c])  rptr[c] <= rptr[c] + PW'(1);
        occ[c] <= occ[c] + OW'(push[c]) - OW'(pop[c]);
      end

      case (state)
        IDLE: if (PASS_START) begin
          state       <= RUN;
          busy        <= 1'b1;
          psum_base_r <= psum_base;
          psum_len_r  <= psum_len;
          psum_cnt    <= '0;
          rr_ptr      <= '0;
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            base_r[c] <= ch_base[c*ADDR_WIDTH +: ADDR_WIDTH];
            len_r[c]  <= ch_len[c*LEN_WIDTH +: LEN_WIDTH];
            issued[c] <= '0;
          end
        end
        RUN: if (all_issued && (!rd_pend || glb_read_valid)) state <= DRAIN;
        DRAIN: if (fifos_empty && !rd_pend && psum_cnt == psum_len_r) begin
          state     <= DONE;
          pass_done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glb_token_dispatcher.sv
// Directed bench for glb_token_dispatcher: GLB responder model, event logs
// sampled on the falling edge, and hand-computed expected streams.
module tb_glb_token_dispatcher;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int NC = 3;
  localparam int LW = 16;
  localparam int FD = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             PASS_START;
  logic [NC*AW-1:0] ch_base;
  logic [NC*LW-1:0] ch_len;
  logic [AW-1:0]    psum_base;
  logic [LW-1:0]    psum_len;
  logic             glb_read_ready;
  logic [AW-1:0]    glb_read_addr;
  logic             glb_read_valid;
  logic [DW-1:0]    glb_read_data;
  logic             glb_write_ready;
  logic             WEB;
  logic [AW-1:0]    glb_write_addr;
  logic [DW-1:0]    glb_write_data;
  logic [NC*DW-1:0] tok_data;
  logic [NC-1:0]    tok_valid;
  logic [NC-1:0]    tok_ready;
  logic [DW-1:0]    pe_psum_data;
  logic             pe_psum_valid;
  logic             pe_psum_ready;
  logic             busy;
  logic             pass_done;

  always #5 clk = ~clk;

  glb_token_dispatcher #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .PASS_START(PASS_START), .ch_base(ch_base), .ch_len(ch_len),
    .psum_base(psum_base), .psum_len(psum_len),
    .glb_read_ready(glb_read_ready), .glb_read_addr(glb_read_addr),
    .glb_read_valid(glb_read_valid), .glb_read_data(glb_read_data),
    .glb_write_ready(glb_write_ready), .WEB(WEB), .glb_write_addr(glb_write_addr),
    .glb_write_data(glb_write_data), .tok_data(tok_data), .tok_valid(tok_valid),
    .tok_ready(tok_ready), .pe_psum_data(pe_psum_data), .pe_psum_valid(pe_psum_valid),
    .pe_psum_ready(pe_psum_ready), .busy(busy), .pass_done(pass_done)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dfun(input logic [AW-1:0] a);
    return 32'h5A00_0000 | {18'b0, a};
  endfunction

  // Event logs filled by the falling-edge monitor
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wr_a[$];
  logic [DW-1:0] wr_d[$];
  logic [DW-1:0] tok_q[NC][$];
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_pop = 0;
  int web_bad = 0;
  int conflict = 0;
  int fail_n = 0;
  logic [31:0] psum_seq;

  assign pe_psum_data = 32'hBEEF_0000 + psum_seq;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      glb_read_valid <= 1'b0;
      glb_read_data  <= '0;
      psum_seq       <= '0;
    end else begin
      glb_read_valid <= glb_read_ready && (rd_q.size() != fail_n);
      glb_read_data  <= glb_read_ready ? dfun(glb_read_addr) : '0;
      if (pe_psum_valid && pe_psum_ready) psum_seq <= psum_seq + 1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (glb_read_ready) rd_q.push_back(glb_read_addr);
    if (glb_write_ready) begin
      wr_a.push_back(glb_write_addr);
      wr_d.push_back(glb_write_data);
      if (WEB !== 1'b0) web_bad++;
      if (glb_read_ready) conflict++;
    end
    for (int c = 0; c < NC; c++)
      if (tok_valid[c] && tok_ready[c]) begin
        tok_q[c].push_back(tok_data[c*DW +: DW]);
        last_pop = cyc;
      end
    if (pass_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_logs();
    rd_q.delete();
    wr_a.delete();
    wr_d.delete();
    for (int c = 0; c < NC; c++) tok_q[c].delete();
  endtask

  task automatic start_pass(input logic [AW-1:0] b0, b1, b2, input logic [LW-1:0] l0, l1, l2,
                            input logic [AW-1:0] pb, input logic [LW-1:0] pl);
    @(posedge clk); #1;
    ch_base    = {b2, b1, b0};
    ch_len     = {l2, l1, l0};
    psum_base  = pb;
    psum_len   = pl;
    PASS_START = 1'b1;
    @(posedge clk); #1;
    PASS_START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_tokens(input string tag, input int c, input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    check($sformatf("%s_ch%0d_count", tag, c), 32'(tok_q[c].size()), 32'(n));
    for (int k = 0; k < n && k < tok_q[c].size(); k++) begin
      a = base + AW'(k);
      check($sformatf("%s_ch%0d_tok%0d", tag, c, k), tok_q[c][k], dfun(a));
    end
  endtask

  initial begin
    int d0;
    int n1;
    int wb0;
    int cf0;
    logic [31:0] seq0;
    logic [AW-1:0] exp_a;

    rst = 1'b1;
    PASS_START = 1'b0;
    ch_base = '0;
    ch_len = '0;
    psum_base = '0;
    psum_len = '0;
    tok_ready = '0;
    pe_psum_valid = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(pass_done), 32'd0);
    check("rst_rd", 32'(glb_read_ready), 32'd0);
    check("rst_web", 32'(WEB), 32'd1);
    check("rst_tokv", 32'(tok_valid), 32'd0);
    check("rst_pready", 32'(pe_psum_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: three channels interleaved, free-flowing PEs
    clear_logs();
    tok_ready = 3'b111;
    d0 = done_cnt;
    start_pass(14'd100, 14'd200, 14'd300, 16'd4, 16'd4, 16'd4, 14'd0, 16'd0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", 200);
    check("t1_nreads", 32'(rd_q.size()), 32'd12);
    for (int i = 0; i < 12 && i < rd_q.size(); i++) begin
      exp_a = AW'(100 * (i % 3 + 1) + i / 3);
      check($sformatf("t1_rd%0d", i), 32'(rd_q[i]), 32'(exp_a));
    end
    check_tokens("t1", 0, 14'd100, 4);
    check_tokens("t1", 1, 14'd200, 4);
    check_tokens("t1", 2, 14'd300, 4);
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);

    // T2: ch1 back-pressured stalls at FIFO depth, others stream on
    clear_logs();
    tok_ready = 3'b101;
    start_pass(14'd1000, 14'd2000, 14'd3000, 16'd8, 16'd8, 16'd8, 14'd0, 16'd0);
    repeat (40) @(posedge clk);
    #1;
    n1 = 0;
    foreach (rd_q[i]) if (rd_q[i] >= 14'd2000 && rd_q[i] < 14'd2100) n1++;
    check("t2_ch1_stalled_reads", 32'(n1), 32'(FD));
    check("t2_ch0_count", 32'(tok_q[0].size()), 32'd8);
    check("t2_ch2_count", 32'(tok_q[2].size()), 32'd8);
    check("t2_ch1_none", 32'(tok_q[1].size()), 32'd0);
    check("t2_ch1_valid", 32'(tok_valid[1]), 32'd1);
    tok_ready = 3'b111;
    wait_done("t2", 200);
    check_tokens("t2", 0, 14'd1000, 8);
    check_tokens("t2", 1, 14'd2000, 8);
    check_tokens("t2", 2, 14'd3000, 8);

    // T3: psum writes pre-empt reads; RR order resumes from ch0
    clear_logs();
    wb0 = web_bad;
    cf0 = conflict;
    seq0 = psum_seq;
    pe_psum_valid = 1'b1;
    start_pass(14'd10, 14'd20, 14'd30, 16'd2, 16'd2, 16'd2, 14'd500, 16'd4);
    wait_done("t3", 200);
    pe_psum_valid = 1'b0;
    check("t3_nwrites", 32'(wr_a.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
      check($sformatf("t3_wa%0d", i), 32'(wr_a[i]), 32'(500 + i));
      check($sformatf("t3_wd%0d", i), wr_d[i], 32'hBEEF_0000 + seq0 + 32'(i));
    end
    check("t3_web_low", 32'(web_bad - wb0), 32'd0);
    check("t3_no_read_on_write", 32'(conflict - cf0), 32'd0);
    check("t3_nreads", 32'(rd_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < rd_q.size(); i++) begin
      exp_a = AW'(10 * (i % 3 + 1) + i / 3);
      check($sformatf("t3_rd%0d", i), 32'(rd_q[i]), 32'(exp_a));
    end
    check_tokens("t3", 1, 14'd20, 2);

    // T4: single active channel; pass_done after the final pop
    clear_logs();
    start_pass(14'd0, 14'd77, 14'd0, 16'd0, 16'd2, 16'd0, 14'd0, 16'd0);
    wait_done("t4", 100);
    check("t4_nreads", 32'(rd_q.size()), 32'd2);
    if (rd_q.size() >= 2) begin
      check("t4_rd0", 32'(rd_q[0]), 32'd77);
      check("t4_rd1", 32'(rd_q[1]), 32'd78);
    end
    check_tokens("t4", 1, 14'd77, 2);
    check("t4_done_after_pop", 32'(done_cyc > last_pop), 32'd1);

    // T5: address wrap plus one dropped return that must be retried
    clear_logs();
    fail_n = 2;
    start_pass(14'd16382, 14'd0, 14'd0, 16'd4, 16'd0, 16'd0, 14'd0, 16'd0);
    wait_done("t5", 100);
    fail_n = 0;
    check("t5_nreads", 32'(rd_q.size()), 32'd5);
    if (rd_q.size() >= 5) begin
      check("t5_rd0", 32'(rd_q[0]), 32'd16382);
      check("t5_rd1", 32'(rd_q[1]), 32'd16383);
      check("t5_rd2_retry", 32'(rd_q[2]), 32'd16383);
      check("t5_rd3", 32'(rd_q[3]), 32'd0);
      check("t5_rd4", 32'(rd_q[4]), 32'd1);
    end
    check_tokens("t5", 0, 14'd16382, 4);

    // T6: async reset mid-pass, then a clean pass
    clear_logs();
    tok_ready = 3'b000;
    start_pass(14'd100, 14'd200, 14'd300, 16'd8, 16'd8, 16'd8, 14'd0, 16'd0);
    repeat (6) @(posedge clk);
    #3;
    check("t6_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_tokv", 32'(tok_valid), 32'd0);
    check("t6_rst_rd", 32'(glb_read_ready), 32'd0);
    check("t6_rst_web", 32'(WEB), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    tok_ready = 3'b111;
    start_pass(14'd40, 14'd50, 14'd60, 16'd3, 16'd3, 16'd3, 14'd0, 16'd0);
    wait_done("t6", 200);
    check("t6_nreads", 32'(rd_q.size()), 32'd9);
    check_tokens("t6", 0, 14'd40, 3);
    check_tokens("t6", 1, 14'd50, 3);
    check_tokens("t6", 2, 14'd60, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
